three_phase_pwm: RTL
====================

# three_phase_pwm

- Center-aligned three-phase PWM generator.
- Sits directly downstream of `inverse_clarke` and consumes its signed fixed-point phase commands `a`, `b`, `c`.
- Converts each phase command into a per-phase compare value and drives complementary high-side and low-side gate signals from a shared up/down carrier counter.
- New commands are double-buffered and take effect only at a carrier period boundary, so duty never changes mid-period.

## Interface
- `D_WIDTH`, 32: width of the phase command inputs (signed, two's complement).
- `Q_BITS`, 10: fractional bits of the inputs; full scale ±2^Q_BITS maps to duty 100 % / 0 %.
- `PERIOD`, 100: half-period of the carrier in clocks; one PWM period is 2*PERIOD clocks.
- `DEADTIME`, 4: dead-time in clocks; only used when `DEADTIME_EN` is defined.
- `clk`, input, 1: clock; all state changes on the rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `enable`, input, 1: run the carrier; when low, the counter is held at 0 and all gate outputs are 0.
- `in_valid`, input, 1: `a`/`b`/`c` carry a new command.
- `in_ready`, output, 1: pending buffer is empty; a command is accepted when `in_valid && in_ready`.
- `a`, `b`, `c`, input, D_WIDTH: signed phase commands in Q(Q_BITS) format.
- `pwm_h`, output, 3: high-side gates; bit 0 = a, bit 1 = b, bit 2 = c.
- `pwm_l`, output, 3: low-side gates, same bit order.
- `period_start`, output, 1: one-clock pulse in the cycle after a boundary.

## Operation
- Duty conversion happens at accept time.
  - Formula: cmp = ((x + 2^Q_BITS) * PERIOD) >>> (Q_BITS+1), saturated to [0, PERIOD].
  - Intermediate width is D_WIDTH + $clog2(PERIOD+1) + 2, signed, so no overflow occurs before the clamp.
  - The three cmp values are stored into the pending registers and `pend_full` is set.
- `in_ready` = !pend_full. It is registered, so it drops in the cycle after an accept.
- Carrier counter `cnt` (width $clog2(PERIOD)) and direction flag `dir`:
  - UP state: cnt = 0 … PERIOD-1. At PERIOD-1, `dir` goes to DOWN and cnt holds for one cycle.
  - DOWN state: cnt = PERIOD-1 … 0. At 0, `dir` goes to UP and cnt holds for one cycle.
  - Every value therefore appears exactly twice per period.
- Boundary: the cycle with dir = DOWN and cnt = 0 while `enable` = 1.
  - At the boundary edge, if `pend_full`: active cmp ← pending cmp and `pend_full` clears.
  - Otherwise the active cmp is retained.
- Simultaneous accept and boundary with the buffer empty: the new command goes to the pending registers only. It is not bypassed into the active registers and applies at the following boundary.
- Raw phase signal: r[i] = (cnt < cmp_active[i]).
  - High time per period is exactly 2*cmp clocks.
  - cmp = 0 gives always low; cmp = PERIOD gives always high.
- Without `DEADTIME_EN`: pwm_h[i] ← r[i] and pwm_l[i] ← !r[i], both registered.
- `enable` deasserted: cnt ← 0, dir ← UP, pwm_h = pwm_l = 0. The pending buffer still accepts commands, and the active cmp values are retained.
  - When `enable` reasserts, the carrier restarts at cnt = 0 in the UP state.

## Timing
- Reset values:
  - cnt = 0, dir = UP.
  - Active cmp = 0 for all three phases; pend_full = 0.
  - in_ready = 1 from the first edge after release.
  - pwm_h = 0, pwm_l = 0, period_start = 0.
- Gate outputs lag `cnt` by 1 clock.
- Command-to-effect latency: from the accept edge to the next boundary edge, plus 1 clock for the output register.
  - Worst case is 2*PERIOD + 1 clocks.
- `period_start` is asserted exactly one clock after each boundary cycle: once per 2*PERIOD clocks while `enable` = 1.
- Asserting `rst_n` low mid-period immediately forces all outputs to their reset values and drops any pending command.
- A held command (`in_valid` = 1, `in_ready` = 0) is not consumed until `in_ready` returns to 1.

## Configuration
- `THREE_PHASE_PWM_DEADTIME_EN` defined: per-phase dead-time insertion.
  - On any edge of r[i], both pwm_h[i] and pwm_l[i] go low.
  - After DEADTIME consecutive clocks with r[i] stable, the side selected by r[i] goes high.
  - If r[i] toggles during the dead-time, the dead-time count restarts.
  - Pulses shorter than DEADTIME clocks are suppressed.
  - pwm_h[i] and pwm_l[i] are never high in the same cycle.
- Macro not defined: no dead-time counters are built and `DEADTIME` is ignored. The low side is the registered complement of the high side.

## Test plan
All scenarios use PERIOD=100, Q_BITS=10.
- Reset, then `enable`=1 with no command: pwm_h = 000 and pwm_l = 111 continuously; `period_start` every 200 clocks.
- Accept a=0, b=512, c=-512: after the next boundary, per period pwm_h[0] is high 100 clocks, pwm_h[1] 150, pwm_h[2] 50; all pulses are centered on cnt = 0.
- Accept a=-1024, b=1023, c=5000: cmp = 0, 99, 100. Required response: pwm_h[0] never high, pwm_h[1] high 198 clocks per period, pwm_h[2] always high (c is clamped).
- Backpressure: two back-to-back commands mid-period.
  - The first is accepted; `in_ready` is 0 until the boundary, so the second is held.
  - The first applies at the boundary; the second is accepted in the cycle after `in_ready` rises and applies one period later.
- Assert `rst_n` low mid-pulse with a command pending: all outputs are 0 immediately; after release `in_ready` = 1 and duty is 0.
- With `THREE_PHASE_PWM_DEADTIME_EN` and DEADTIME=4, a=0:
  - Both gates are low for 4 clocks at each transition.
  - pwm_h[0] is high 96 clocks per period.
  - pwm_h & pwm_l is never nonzero.

Source files
------------

// File: rtl/three_phase_pwm.sv
// three_phase_pwm: center-aligned 3-phase PWM with double-buffered duty commands.
// Define THREE_PHASE_PWM_DEADTIME_EN to add per-phase dead-time insertion.
module three_phase_pwm #(
  parameter int D_WIDTH  = 32,
  parameter int Q_BITS   = 10,
  parameter int PERIOD   = 100,
  parameter int DEADTIME = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [D_WIDTH-1:0] a,
  input  logic signed [D_WIDTH-1:0] b,
  input  logic signed [D_WIDTH-1:0] c,
  output logic [2:0]                pwm_h,
  output logic [2:0]                pwm_l,
  output logic                      period_start
);
  localparam int CW = $clog2(PERIOD);
  localparam int MW = $clog2(PERIOD + 1);
  localparam int W  = D_WIDTH + MW + 2;
  localparam logic signed [W-1:0] FS = W'(1) << Q_BITS;
  localparam logic signed [W-1:0] PS = W'(PERIOD);
  typedef enum logic {UP, DN} dir_t;
  typedef logic [MW-1:0] cmp_t;
  function automatic cmp_t to_cmp(input logic signed [D_WIDTH-1:0] x);
    logic signed [W-1:0] xs, p;
    xs = {{(W - D_WIDTH){x[D_WIDTH-1]}}, x};
    p  = ((xs + FS) * PS) >>> (Q_BITS + 1);
    return p < 0 ? '0 : p > PS ? MW'(PERIOD) : p[MW-1:0];
  endfunction
  logic [CW-1:0]      cnt_q, cnt_d;
  dir_t               dir_q, dir_d;
  logic [2:0][MW-1:0] act_q, act_d, pend_q, pend_d;
  logic               pend_full_q, pend_full_d;
  logic               in_ready_q, in_ready_d;
  logic               ps_q, ps_d;
  logic [2:0]         pwm_h_q, pwm_h_d, pwm_l_q, pwm_l_d;
  logic [2:0]         r;
  logic               boundary, accept;
  always_comb begin
    boundary = enable && dir_q == DN && cnt_q == '0;
    accept   = in_valid && in_ready_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    if (!enable) begin
      cnt_d = '0;
      dir_d = UP;
    end else if (dir_q == UP) begin
      if (cnt_q == CW'(PERIOD - 1)) dir_d = DN;
      else cnt_d = cnt_q + CW'(1);
    end else begin
      if (cnt_q == '0) dir_d = UP;
      else cnt_d = cnt_q - CW'(1);
    end
    act_d       = boundary && pend_full_q ? pend_q : act_q;
    pend_d      = accept ? {to_cmp(c), to_cmp(b), to_cmp(a)} : pend_q;
    pend_full_d = accept || (pend_full_q && !boundary);
    in_ready_d  = !pend_full_d;
    ps_d        = boundary;
    for (int i = 0; i < 3; i++) r[i] = MW'(cnt_q) < act_q[i];
  end
`ifdef THREE_PHASE_PWM_DEADTIME_EN
  localparam int DW = $clog2(DEADTIME + 2);
  logic [2:0]         r_prev_q;
  logic [2:0][DW-1:0] dt_q, dt_d, s;
  // s counts how many consecutive cycles r has held its current value, saturating
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      s[i]       = r[i] != r_prev_q[i] ? DW'(1) :
                   dt_q[i] == DW'(DEADTIME + 1) ? dt_q[i] : dt_q[i] + DW'(1);
      dt_d[i]    = enable ? s[i] : '0;
      pwm_h_d[i] = enable && s[i] > DW'(DEADTIME) && r[i];
      pwm_l_d[i] = enable && s[i] > DW'(DEADTIME) && !r[i];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_q <= '0;
      dt_q     <= '0;
    end else begin
      r_prev_q <= r;
      dt_q     <= dt_d;
    end
  end
`else
  always_comb begin
    pwm_h_d = enable ? r : '0;
    pwm_l_d = enable ? ~r : '0;
  end
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      dir_q       <= UP;
      act_q       <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      in_ready_q  <= 1'b0;
      ps_q        <= 1'b0;
      pwm_h_q     <= '0;
      pwm_l_q     <= '0;
    end else begin
      cnt_q       <= cnt_d;
      dir_q       <= dir_d;
      act_q       <= act_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      in_ready_q  <= in_ready_d;
      ps_q        <= ps_d;
      pwm_h_q     <= pwm_h_d;
      pwm_l_q     <= pwm_l_d;
    end
  end
  assign in_ready     = in_ready_q;
  assign period_start = ps_q;
  assign pwm_h        = pwm_h_q;
  assign pwm_l        = pwm_l_q;
endmodule
